exe_muldiv_unit: RTL and testbench
==================================

// Module: exe_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EXE stage. Executes MULT, MULTU, DIV and DIVU
//  on Rs/Rt and drives the 64-bit {HI,LO} result onto OUT_ALU64, which feeds the
//  EXE/MEM register. It holds Stall_EXE while working so that upstream stages freeze.
// PARAMETERS
//  WIDTH  32  operand width; the result is 2*WIDTH bits
// PORTS
//  Clk          in   1        clock, rising edge
//  Rst_n        in   1        asynchronous active-low reset
//  Start        in   1        begin operation; sampled only in IDLE
//  Op           in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  Rs_data_EXE  in   WIDTH    multiplicand / dividend
//  Rt_data_EXE  in   WIDTH    multiplier / divisor
//  Flush        in   1        synchronous abort of the current operation
//  Busy         out  1        registered; 1 in any state other than IDLE
//  Stall_EXE    out  1        combinational: Busy | (Start & ~Flush & state==IDLE)
//  Done         out  1        registered one-cycle pulse; result valid
//  Div_by_zero  out  1        registered; updated together with Done
//  OUT_ALU64    out  2*WIDTH  {HI,LO}; holds its value until the next Done
// BEHAVIOUR
//  Reset (async, Rst_n=0): state=IDLE, Busy=0, Done=0, Div_by_zero=0, OUT_ALU64=0,
//    and all internal operand, accumulator and count registers are 0.
//  The reset takes effect immediately, including in the middle of an operation.
//  FSM states: IDLE -> BUSY -> FIX -> IDLE.
//  IDLE: on an edge with Start=1 and Flush=0:
//    - latch Op
//    - latch operand magnitudes (absolute value if Op[0]=1 and the MSB is set)
//    - latch the result sign bits
//    - set cnt=0 and go to BUSY.
//    Done defaults to 0 on every edge where it is not explicitly set.
//  BUSY: one radix-2 iteration per edge, then cnt++.
//    On the edge where cnt==WIDTH-1, perform the final iteration and go to FIX.
//    - Multiply: shift-add on the 2*WIDTH accumulator.
//    - Divide: restoring shift-subtract. Quotient goes to LO, remainder to HI.
//  FIX: apply signs and write OUT_ALU64, set Done=1 and Div_by_zero, then go to IDLE.
//    - MULT: negate the 64-bit product if signA^signB.
//    - DIV: negate the quotient if signA^signB; negate the remainder if signA.
//  Latency: Start sampled at edge t0. Done=1 and OUT_ALU64 valid in the cycle after
//    edge t0+WIDTH+1 (edge 33 for WIDTH=32). Stall_EXE drops in that same cycle.
//  Divide by zero (Rt==0 with Op=1x):
//    - full latency still applies
//    - OUT_ALU64 = {Rs_data_EXE as latched (original sign), {WIDTH{1'b1}}}
//    - Div_by_zero=1.
//  For every other operation Div_by_zero=0 at Done.
//  Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives Q=0x80000000, R=0
//    (wraps; no flag).
//  Start while BUSY or FIX is ignored; operands are never re-sampled mid-operation.
//  Flush=1 in BUSY or FIX: go to IDLE on the next edge.
//    - Done stays 0 and OUT_ALU64 is unchanged.
//    - A Start may be accepted on the following edge.
//  Flush and Start on the same edge in IDLE: Flush wins and nothing starts.
//  All arithmetic is modulo 2*WIDTH. Operands are unsigned internally after
//    magnitude conversion.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done at edge t0+33, OUT_ALU64=0xFFFFFFFE_00000001.
//  2. MULT 0xFFFFFFFD(-3)*7 -> OUT_ALU64=0xFFFFFFFF_FFFFFFEB; Stall_EXE high t0..t0+32.
//  3. DIV 0xFFFFFFF9(-7)/2 -> OUT_ALU64=0xFFFFFFFF_FFFFFFFD (R=-1, Q=-3); DIV 0x80000000/-1 -> 0x00000000_80000000.
//  4. DIVU 0x12345678/0 -> Div_by_zero=1, OUT_ALU64=0x12345678_FFFFFFFF at edge t0+33.
//  5. Flush at t0+10 -> no Done, OUT_ALU64 keeps the previous result; Start at the next edge completes normally.
//  6. Rst_n low mid-BUSY (asynchronous, between edges) -> Busy/Done/OUT_ALU64 become 0 at once; Start and Busy raised together are ignored.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit -- iterative radix-2 multiply/divide unit for the EXE stage.
// Executes MULTU/MULT/DIVU/DIV on Rs/Rt over WIDTH iterations, then applies
// the result signs and publishes {HI,LO} on OUT_ALU64. Stall_EXE freezes the
// upstream stages while an operation is in flight.
// Ports:
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Op           begin operation (IDLE only); 00 MULTU 01 MULT 10 DIVU 11 DIV
//   Rs_data_EXE         multiplicand / dividend
//   Rt_data_EXE         multiplier / divisor
//   Flush               synchronous abort of the current operation
//   Busy                registered, high outside IDLE
//   Stall_EXE           combinational pipeline stall
//   Done, Div_by_zero   registered one-cycle result pulse and divide-by-zero flag
//   OUT_ALU64           {HI,LO} result, held until the next Done
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   Rs_data_EXE,
  input  logic [WIDTH-1:0]   Rt_data_EXE,
  input  logic               Flush,
  output logic               Busy,
  output logic               Stall_EXE,
  output logic               Done,
  output logic               Div_by_zero,
  output logic [2*WIDTH-1:0] OUT_ALU64
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               start_ok;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH-1:0] mul_step, div_step, step_next;
  logic [WIDTH-1:0]   quot, rem, quot_s, rem_s, a_orig;
  logic [2*WIDTH-1:0] fix_res;
  logic               div_zero;

  assign start_ok  = Start & ~Flush & (state == S_IDLE);
  assign Stall_EXE = Busy | start_ok;

  // Operand magnitudes: only signed ops with a set MSB are negated.
  assign rs_neg = Op[0] & Rs_data_EXE[WIDTH-1];
  assign rt_neg = Op[0] & Rt_data_EXE[WIDTH-1];
  assign rs_mag = rs_neg ? (-Rs_data_EXE) : Rs_data_EXE;
  assign rt_mag = rt_neg ? (-Rt_data_EXE) : Rt_data_EXE;

  // Shift-add: the multiplier starts in the low half and is consumed LSB first;
  // the extra sum bit carries into the shifted-down accumulator.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
  assign mul_step = {add_sum, acc[WIDTH-1:1]};

  // Restoring divide: {rem,quot} shifts left; a W+1-bit trial subtraction
  // decides whether the quotient bit shifted in is 1.
  assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
  assign div_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign step_next = op_q[1] ? div_step : mul_step;

  assign quot     = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quot_s   = (sign_a ^ sign_b) ? (-quot) : quot;
  assign rem_s    = sign_a ? (-rem) : rem;
  // Re-negating the magnitude recovers the dividend as originally presented.
  assign a_orig   = sign_a ? (-a_mag) : a_mag;
  assign div_zero = op_q[1] & (b_mag == '0);

  always_comb begin
    fix_res = acc;
    if (op_q[1]) begin
      if (div_zero) fix_res = {a_orig, {WIDTH{1'b1}}};
      else          fix_res = {rem_s, quot_s};
    end else if (sign_a ^ sign_b) begin
      fix_res = -acc;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_next = S_BUSY;
      S_BUSY: begin
        if (Flush)                          state_next = S_IDLE;
        else if (cnt == CW'(WIDTH - 1))     state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= S_IDLE;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Div_by_zero <= 1'b0;
      OUT_ALU64   <= '0;
      op_q        <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != S_IDLE);
      Done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            op_q   <= Op;
            a_mag  <= rs_mag;
            b_mag  <= rt_mag;
            sign_a <= rs_neg;
            sign_b <= rt_neg;
            acc    <= {{WIDTH{1'b0}}, rs_mag};
            cnt    <= '0;
          end
        end
        S_BUSY: begin
          if (!Flush) begin
            acc <= step_next;
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (!Flush) begin
            OUT_ALU64   <= fix_res;
            Done        <= 1'b1;
            Div_by_zero <= div_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;
  localparam int W = 32;

  logic           Clk, Rst_n, Start, Flush;
  logic [1:0]     Op;
  logic [W-1:0]   Rs_data_EXE, Rt_data_EXE;
  logic           Busy, Stall_EXE, Done, Div_by_zero;
  logic [2*W-1:0] OUT_ALU64;

  exe_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .Rs_data_EXE(Rs_data_EXE), .Rt_data_EXE(Rt_data_EXE), .Flush(Flush),
    .Busy(Busy), .Stall_EXE(Stall_EXE), .Done(Done),
    .Div_by_zero(Div_by_zero), .OUT_ALU64(OUT_ALU64)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] res;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  localparam int NV = 14;
  vec_t  vecs[NV];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  logic [63:0] last_res;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one operation (entered just after a rising edge) and follow it to Done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] res, input logic dbz);
    exp_t e;
    int   lat;
    bit   stall_ok;
    e.res = res;
    e.dbz = dbz;
    lat = -1;
    stall_ok = 1'b1;
    Op = op; Rs_data_EXE = rs; Rt_data_EXE = rt; Start = 1'b1;
    #1;
    if (!Stall_EXE) stall_ok = 1'b0;
    @(posedge Clk);
    sb.push_back(e);
    #1;
    Start = 1'b0;
    Rs_data_EXE = $urandom;
    Rt_data_EXE = $urandom;
    for (int n = 1; n <= 40; n++) begin
      if (!Stall_EXE) stall_ok = 1'b0;
      if (n == 5) begin
        Start = 1'b1;
        Op = 2'($urandom);
      end
      if (n == 6) Start = 1'b0;
      @(posedge Clk);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
    end
    Start = 1'b0;
    e = sb.pop_front();
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_done actual=no_done required=done_within_40", tag);
    end else begin
      chk({tag, "_latency"}, 64'(lat), 64'd33);
      chk({tag, "_result"}, OUT_ALU64, e.res);
      chk({tag, "_dbz"}, 64'(Div_by_zero), 64'(e.dbz));
      chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      chk({tag, "_stall_done"}, 64'(Stall_EXE), 64'd0);
      @(posedge Clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
      chk({tag, "_hold"}, OUT_ALU64, e.res);
      last_res = e.res;
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    vecs[4]  = '{2'b10, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF, 1'b1};
    vecs[5]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0};
    vecs[7]  = '{2'b10, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
    vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 1'b0};
    vecs[12] = '{2'b00, 32'h00000000, 32'h12345678, 64'h00000000_00000000, 1'b0};
    vecs[13] = '{2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 1'b0};

    Rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00;
    Rs_data_EXE = '0; Rt_data_EXE = '0;
    last_res = '0;

    #12;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_dbz", 64'(Div_by_zero), 64'd0);
    chk("reset_out", OUT_ALU64, 64'd0);
    chk("reset_stall", 64'(Stall_EXE), 64'd0);
    #10;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].res, vecs[i].dbz);

    // Flush in IDLE together with Start: nothing starts.
    Start = 1'b1; Flush = 1'b1; Op = 2'b00; Rs_data_EXE = 32'd9; Rt_data_EXE = 32'd9;
    #1;
    chk("idle_flush_stall", 64'(Stall_EXE), 64'd0);
    @(posedge Clk);
    #1;
    Start = 1'b0; Flush = 1'b0;
    chk("idle_flush_busy", 64'(Busy), 64'd0);

    // Flush mid-BUSY at edge t0+10, then restart on the following edge.
    Op = 2'b00; Rs_data_EXE = 32'd11; Rt_data_EXE = 32'd13; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge Clk);
      #1;
    end
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    chk("flush_busy_idle", 64'(Busy), 64'd0);
    chk("flush_busy_done", 64'(Done), 64'd0);
    chk("flush_busy_out", OUT_ALU64, last_res);
    run_op("after_flush", 2'b00, 32'd3, 32'd5, 64'd15, 1'b0);

    // Flush while in FIX (entered at edge t0+32): result never published.
    Op = 2'b01; Rs_data_EXE = 32'hFFFFFFFE; Rt_data_EXE = 32'd4; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(posedge Clk);
      #1;
    end
    chk("fix_busy", 64'(Busy), 64'd1);
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    chk("flush_fix_done", 64'(Done), 64'd0);
    chk("flush_fix_out", OUT_ALU64, 64'd15);
    chk("flush_fix_idle", 64'(Busy), 64'd0);

    // Asynchronous reset in the middle of BUSY.
    Op = 2'b10; Rs_data_EXE = 32'd1000; Rt_data_EXE = 32'd3; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge Clk);
      #1;
    end
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(Busy), 64'd0);
    chk("async_rst_done", 64'(Done), 64'd0);
    chk("async_rst_out", OUT_ALU64, 64'd0);
    chk("async_rst_stall", 64'(Stall_EXE), 64'd0);
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_start_ignored", 64'(Busy), 64'd0);
    Start = 1'b0;
    #2;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    run_op("after_rst", 2'b10, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
